sha256_port_arbiter: RTL and testbench

Four-port front-end that shares a single SHA-256 compression core between four independent requesters. It accepts per-port commands on the `reqN_cmd_in`/`reqN_data_in` buses and grants the core to one port at a time in round-robin order. It forwards the owner's 16 message words to the core and returns the 256-bit digest as eight 32-bit words with status on `out_dataN`/`out_respN`. It sits between the bench/host-facing request ports and the hashing datapath.

---
 rtl/sha256_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_sha256_port_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_port_arbiter.sv
// -----------------------------------------------------------------------------
// sha256_port_arbiter
//
// Shares one SHA-256 compression core between four requesters. Each port
// issues NOP / REQ / WORD commands. Ports are granted the core one at a time
// in round-robin order. The owner streams its 16 message words to the core.
// The resulting digest is returned to the owner as eight 32-bit words.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   reqN_cmd_in/reqN_data_in per-port command and data (N = 1..4)
//   out_dataN/out_respN      per-port registered response data and code
//   core_start               marks the first message word of a block
//   core_word_valid/core_word message word stream to the core
//   core_done/core_digest    digest return from the core (H0 in [255:224])
//   o_dbg_state              current FSM state (IDLE/LOAD/WAIT/OUT)
//   o_dbg_word_cnt           number of message words accepted so far
//   o_dbg_pending            per-port pending-request bits
//
// Handshake: there is no backpressure. A command is consumed in the cycle it
// is presented. Its outcome (grant, error, digest word) is a registered
// response that appears on out_respN in the following cycle and lasts for
// exactly one cycle. out_dataN is zero unless out_respN is "digest word".
// -----------------------------------------------------------------------------
module sha256_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int RESP_WIDTH = 2,
    parameter int CMD_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CMD_WIDTH-1:0]  req1_cmd_in,
    input  logic [CMD_WIDTH-1:0]  req2_cmd_in,
    input  logic [CMD_WIDTH-1:0]  req3_cmd_in,
    input  logic [CMD_WIDTH-1:0]  req4_cmd_in,
    input  logic [DATA_WIDTH-1:0] req1_data_in,
    input  logic [DATA_WIDTH-1:0] req2_data_in,
    input  logic [DATA_WIDTH-1:0] req3_data_in,
    input  logic [DATA_WIDTH-1:0] req4_data_in,
    output logic [DATA_WIDTH-1:0] out_data1,
    output logic [DATA_WIDTH-1:0] out_data2,
    output logic [DATA_WIDTH-1:0] out_data3,
    output logic [DATA_WIDTH-1:0] out_data4,
    output logic [RESP_WIDTH-1:0] out_resp1,
    output logic [RESP_WIDTH-1:0] out_resp2,
    output logic [RESP_WIDTH-1:0] out_resp3,
    output logic [RESP_WIDTH-1:0] out_resp4,
    output logic                  core_start,
    output logic                  core_word_valid,
    output logic [31:0]           core_word,
    input  logic                  core_done,
    input  logic [255:0]          core_digest,
    output logic [1:0]            o_dbg_state,
    output logic [3:0]            o_dbg_word_cnt,
    output logic [3:0]            o_dbg_pending
);

    localparam logic [CMD_WIDTH-1:0]  CMD_NOP     = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0]  CMD_REQ     = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0]  CMD_WORD    = CMD_WIDTH'(2);
    localparam logic [RESP_WIDTH-1:0] RESP_IDLE   = RESP_WIDTH'(0);
    localparam logic [RESP_WIDTH-1:0] RESP_DIGEST = RESP_WIDTH'(1);
    localparam logic [RESP_WIDTH-1:0] RESP_ERR    = RESP_WIDTH'(2);
    localparam logic [RESP_WIDTH-1:0] RESP_GRANT  = RESP_WIDTH'(3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    // Port inputs gathered into arrays (index 0 = port 1)
    logic [CMD_WIDTH-1:0]  w_cmd  [4];
    logic [DATA_WIDTH-1:0] w_data [4];

    assign w_cmd[0]  = req1_cmd_in;
    assign w_cmd[1]  = req2_cmd_in;
    assign w_cmd[2]  = req3_cmd_in;
    assign w_cmd[3]  = req4_cmd_in;
    assign w_data[0] = req1_data_in;
    assign w_data[1] = req2_data_in;
    assign w_data[2] = req3_data_in;
    assign w_data[3] = req4_data_in;

    state_t                r_state,    w_state_nxt;
    logic [3:0]            r_pending,  w_pending_nxt;
    logic [1:0]            r_owner,    w_owner_nxt;
    logic                  r_owner_vld, w_owner_vld_nxt;
    logic [1:0]            r_rr_ptr,   w_rr_ptr_nxt;
    logic [3:0]            r_word_cnt, w_word_cnt_nxt;
    logic [2:0]            r_out_cnt,  w_out_cnt_nxt;
    logic [255:0]          r_digest,   w_digest_nxt;
    logic [DATA_WIDTH-1:0] r_out_data [4];
    logic [DATA_WIDTH-1:0] w_out_data_nxt [4];
    logic [RESP_WIDTH-1:0] r_out_resp [4];
    logic [RESP_WIDTH-1:0] w_out_resp_nxt [4];
    logic                  r_core_start, w_core_start_nxt;
    logic                  r_core_word_valid, w_core_word_valid_nxt;
    logic [31:0]           r_core_word, w_core_word_nxt;

    // Command decode
    logic [3:0] w_req_ok;
    logic [3:0] w_err;
    logic       w_word_ok;

    always_comb begin
        w_req_ok  = '0;
        w_err     = '0;
        w_word_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            case (w_cmd[i])
                CMD_NOP: ;
                CMD_REQ: begin
                    if (r_pending[i] || (r_owner_vld && r_owner == 2'(i)))
                        w_err[i] = 1'b1;
                    else
                        w_req_ok[i] = 1'b1;
                end
                CMD_WORD: begin
                    if (r_state == S_LOAD && r_owner_vld && r_owner == 2'(i))
                        w_word_ok = 1'b1;
                    else
                        w_err[i] = 1'b1;
                end
                default: w_err[i] = 1'b1;
            endcase
        end
    end

    // Round-robin pick. On the last OUT cycle the pointer that takes effect
    // is owner+1, so arbitration uses that value directly instead of the
    // stale register.
    logic [3:0] w_cand;
    logic [1:0] w_arb_ptr;
    logic [1:0] w_scan_idx;
    logic       w_gnt_vld;
    logic [1:0] w_gnt_idx;

    always_comb begin
        w_cand     = r_pending | w_req_ok;
        w_arb_ptr  = (r_state == S_OUT) ? r_owner + 2'd1 : r_rr_ptr;
        w_scan_idx = 2'd0;
        w_gnt_vld  = 1'b0;
        w_gnt_idx  = 2'd0;
        // Scan farthest-first so the nearest candidate is the last writer
        for (int i = 3; i >= 0; i--) begin
            w_scan_idx = w_arb_ptr + 2'(i);
            if (w_cand[w_scan_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_scan_idx;
            end
        end
    end

    // Digest word for the next OUT cycle: H[out_cnt+1]
    logic [2:0]  w_sel;
    logic [31:0] w_digest_word;

    assign w_sel         = 3'd6 - r_out_cnt;
    assign w_digest_word = r_digest[{w_sel, 5'd0} +: 32];

    // Next-state and output logic
    logic w_do_arb;

    always_comb begin
        w_state_nxt           = r_state;
        w_pending_nxt         = r_pending | w_req_ok;
        w_owner_nxt           = r_owner;
        w_owner_vld_nxt       = r_owner_vld;
        w_rr_ptr_nxt          = r_rr_ptr;
        w_word_cnt_nxt        = r_word_cnt;
        w_out_cnt_nxt         = r_out_cnt;
        w_digest_nxt          = r_digest;
        w_core_start_nxt      = 1'b0;
        w_core_word_valid_nxt = 1'b0;
        w_core_word_nxt       = '0;
        w_do_arb              = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_out_resp_nxt[i] = w_err[i] ? RESP_ERR : RESP_IDLE;
            w_out_data_nxt[i] = '0;
        end

        case (r_state)
            S_IDLE: w_do_arb = 1'b1;
            S_LOAD: begin
                if (w_word_ok) begin
                    w_core_word_valid_nxt = 1'b1;
                    w_core_word_nxt       = w_data[r_owner][31:0];
                    w_core_start_nxt      = (r_word_cnt == 4'd0);
                    if (r_word_cnt == 4'd15) begin
                        w_word_cnt_nxt = 4'd0;
                        w_state_nxt    = S_WAIT;
                    end else begin
                        w_word_cnt_nxt = r_word_cnt + 4'd1;
                    end
                end
            end
            S_WAIT: begin
                if (core_done) begin
                    // H0 is driven straight from the core bus so it lands
                    // one cycle after core_done.
                    w_digest_nxt               = core_digest;
                    w_out_resp_nxt[r_owner]    = RESP_DIGEST;
                    w_out_data_nxt[r_owner]    = DATA_WIDTH'(core_digest[255:224]);
                    w_out_cnt_nxt              = 3'd0;
                    w_state_nxt                = S_OUT;
                end
            end
            S_OUT: begin
                // out_cnt = k means H[k] is currently on the port; the
                // register is loaded one word ahead.
                if (r_out_cnt != 3'd7) begin
                    w_out_resp_nxt[r_owner] = RESP_DIGEST;
                    w_out_data_nxt[r_owner] = DATA_WIDTH'(w_digest_word);
                    w_out_cnt_nxt           = r_out_cnt + 3'd1;
                end else begin
                    w_rr_ptr_nxt    = r_owner + 2'd1;
                    w_owner_vld_nxt = 1'b0;
                    w_out_cnt_nxt   = 3'd0;
                    w_state_nxt     = S_IDLE;
                    w_do_arb        = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_do_arb && w_gnt_vld) begin
            w_owner_nxt                = w_gnt_idx;
            w_owner_vld_nxt            = 1'b1;
            w_pending_nxt[w_gnt_idx]   = 1'b0;
            w_word_cnt_nxt             = 4'd0;
            w_state_nxt                = S_LOAD;
            w_out_resp_nxt[w_gnt_idx]  = RESP_GRANT;
            w_out_data_nxt[w_gnt_idx]  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state           <= S_IDLE;
            r_pending         <= '0;
            r_owner           <= 2'd0;
            r_owner_vld       <= 1'b0;
            r_rr_ptr          <= 2'd0;
            r_word_cnt        <= 4'd0;
            r_out_cnt         <= 3'd0;
            r_digest          <= '0;
            r_core_start      <= 1'b0;
            r_core_word_valid <= 1'b0;
            r_core_word       <= '0;
            for (int i = 0; i < 4; i++) begin
                r_out_data[i] <= '0;
                r_out_resp[i] <= RESP_IDLE;
            end
        end else begin
            r_state           <= w_state_nxt;
            r_pending         <= w_pending_nxt;
            r_owner           <= w_owner_nxt;
            r_owner_vld       <= w_owner_vld_nxt;
            r_rr_ptr          <= w_rr_ptr_nxt;
            r_word_cnt        <= w_word_cnt_nxt;
            r_out_cnt         <= w_out_cnt_nxt;
            r_digest          <= w_digest_nxt;
            r_core_start      <= w_core_start_nxt;
            r_core_word_valid <= w_core_word_valid_nxt;
            r_core_word       <= w_core_word_nxt;
            for (int i = 0; i < 4; i++) begin
                r_out_data[i] <= w_out_data_nxt[i];
                r_out_resp[i] <= w_out_resp_nxt[i];
            end
        end
    end

    assign out_data1       = r_out_data[0];
    assign out_data2       = r_out_data[1];
    assign out_data3       = r_out_data[2];
    assign out_data4       = r_out_data[3];
    assign out_resp1       = r_out_resp[0];
    assign out_resp2       = r_out_resp[1];
    assign out_resp3       = r_out_resp[2];
    assign out_resp4       = r_out_resp[3];
    assign core_start      = r_core_start;
    assign core_word_valid = r_core_word_valid;
    assign core_word       = r_core_word;
    assign o_dbg_state     = r_state;
    assign o_dbg_word_cnt  = r_word_cnt;
    assign o_dbg_pending   = r_pending;

endmodule

// File: tb/tb_sha256_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sha256_port_arbiter
//
// Directed bench for sha256_port_arbiter. The bench plays both the requesters
// and the compression core; core_done/core_digest are driven by hand with
// known digests. Each scenario task drives stimulus and checks inline.
// -----------------------------------------------------------------------------
module tb_sha256_port_arbiter;

    localparam logic [3:0] C_NOP  = 4'h0;
    localparam logic [3:0] C_REQ  = 4'h1;
    localparam logic [3:0] C_WORD = 4'h2;

    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    // Clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]   tb_cmd  [4];
    logic [31:0]  tb_data [4];
    logic [31:0]  out_data [4];
    logic [1:0]   out_resp [4];
    logic         core_start;
    logic         core_word_valid;
    logic [31:0]  core_word;
    logic         core_done;
    logic [255:0] core_digest;
    logic [1:0]   dbg_state;
    logic [3:0]   dbg_word_cnt;
    logic [3:0]   dbg_pending;

    logic [31:0]  abc_h [8];
    logic [31:0]  msg   [16];

    int n_checks = 0;
    int n_errors = 0;

    sha256_port_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .req1_cmd_in     (tb_cmd[0]),
        .req2_cmd_in     (tb_cmd[1]),
        .req3_cmd_in     (tb_cmd[2]),
        .req4_cmd_in     (tb_cmd[3]),
        .req1_data_in    (tb_data[0]),
        .req2_data_in    (tb_data[1]),
        .req3_data_in    (tb_data[2]),
        .req4_data_in    (tb_data[3]),
        .out_data1       (out_data[0]),
        .out_data2       (out_data[1]),
        .out_data3       (out_data[2]),
        .out_data4       (out_data[3]),
        .out_resp1       (out_resp[0]),
        .out_resp2       (out_resp[1]),
        .out_resp3       (out_resp[2]),
        .out_resp4       (out_resp[3]),
        .core_start      (core_start),
        .core_word_valid (core_word_valid),
        .core_word       (core_word),
        .core_done       (core_done),
        .core_digest     (core_digest),
        .o_dbg_state     (dbg_state),
        .o_dbg_word_cnt  (dbg_word_cnt),
        .o_dbg_pending   (dbg_pending)
    );

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cmds();
        for (int i = 0; i < 4; i++) begin
            tb_cmd[i]  = C_NOP;
            tb_data[i] = 32'h0;
        end
    endtask

    task automatic set_cmd(input int p, input logic [3:0] c, input logic [31:0] d);
        tb_cmd[p]  = c;
        tb_data[p] = d;
    endtask

    task automatic apply_reset();
        rst         = 1'b0;
        core_done   = 1'b0;
        core_digest = '0;
        clear_cmds();
        repeat (2) step();
        rst = 1'b1;
    endtask

    task automatic feed_words(input int p);
        for (int w = 0; w < 16; w++) begin
            set_cmd(p, C_WORD, msg[w]);
            step();
        end
        clear_cmds();
    endtask

    task automatic pulse_done(input logic [255:0] dig);
        core_done   = 1'b1;
        core_digest = dig;
        step();
        core_done   = 1'b0;
        core_digest = '0;
    endtask

    // Scenarios
    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_resp[i] !== 2'b00 || out_data[i] !== 32'h0) begin
                n_errors++;
                $display("FAIL reset_port%0d resp=%b data=%h expected 00/0", i + 1, out_resp[i], out_data[i]);
            end
        end
        n_checks++;
        if ({core_start, core_word_valid, core_word} !== 34'h0 || dbg_state !== 2'd0 || dbg_pending !== 4'h0) begin
            n_errors++;
            $display("FAIL reset_core start=%b valid=%b word=%h state=%0d pend=%b expected zeros",
                     core_start, core_word_valid, core_word, dbg_state, dbg_pending);
        end
    endtask

    task automatic test_single_hash();
        apply_reset();
        set_cmd(0, C_REQ, 32'h0);
        step();
        clear_cmds();
        n_checks++;
        if (out_resp[0] !== 2'b11 || out_resp[1] !== 2'b00) begin
            n_errors++;
            $display("FAIL single_grant resp1=%b resp2=%b expected 11/00", out_resp[0], out_resp[1]);
        end
        for (int w = 0; w < 16; w++) begin
            set_cmd(0, C_WORD, msg[w]);
            step();
            n_checks++;
            if (core_word_valid !== 1'b1 || core_word !== msg[w] || core_start !== (w == 0)) begin
                n_errors++;
                $display("FAIL single_word%0d valid=%b word=%h start=%b expected 1/%h/%b",
                         w, core_word_valid, core_word, core_start, msg[w], (w == 0));
            end
        end
        clear_cmds();
        n_checks++;
        if (dbg_state !== 2'd2) begin
            n_errors++;
            $display("FAIL single_wait state=%0d expected 2", dbg_state);
        end
        step();
        n_checks++;
        if (core_word_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_valid_drop valid=%b expected 0", core_word_valid);
        end
        step();
        pulse_done(ABC_DIGEST);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (out_resp[0] !== 2'b01 || out_data[0] !== abc_h[k]) begin
                n_errors++;
                $display("FAIL single_digest%0d resp=%b data=%h expected 01/%h", k, out_resp[0], out_data[0], abc_h[k]);
            end
            step();
        end
        n_checks++;
        if (out_resp[0] !== 2'b00 || out_data[0] !== 32'h0 || dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL single_after resp=%b data=%h state=%0d expected 00/0/0", out_resp[0], out_data[0], dbg_state);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0]  mask;
        logic [255:0] dig;
        apply_reset();
        for (int p = 0; p < 4; p++) set_cmd(p, C_REQ, 32'h0);
        step();
        clear_cmds();
        n_checks++;
        if (out_resp[0] !== 2'b11 || out_resp[1] !== 2'b00 || dbg_pending !== 4'b1110) begin
            n_errors++;
            $display("FAIL rr_first resp1=%b resp2=%b pend=%b expected 11/00/1110", out_resp[0], out_resp[1], dbg_pending);
        end
        for (int o = 0; o < 4; o++) begin
            mask = 32'h01010101 * (o + 1);
            dig  = ABC_DIGEST ^ {8{mask}};
            feed_words(o);
            pulse_done(dig);
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (out_resp[o] !== 2'b01 || out_data[o] !== (abc_h[k] ^ mask)) begin
                    n_errors++;
                    $display("FAIL rr_digest_p%0d_w%0d resp=%b data=%h expected 01/%h",
                             o + 1, k, out_resp[o], out_data[o], abc_h[k] ^ mask);
                end
                step();
            end
            if (o < 3) begin
                n_checks++;
                if (out_resp[o + 1] !== 2'b11 || out_resp[o] !== 2'b00) begin
                    n_errors++;
                    $display("FAIL rr_next_grant_p%0d resp=%b prev=%b expected 11/00", o + 2, out_resp[o + 1], out_resp[o]);
                end
            end else begin
                n_checks++;
                if (dbg_state !== 2'd0 || dbg_pending !== 4'h0) begin
                    n_errors++;
                    $display("FAIL rr_done state=%0d pend=%b expected 0/0000", dbg_state, dbg_pending);
                end
            end
        end
    endtask

    task automatic test_errors();
        apply_reset();
        set_cmd(2, C_REQ, 32'h0);
        step();
        clear_cmds();
        for (int w = 0; w < 3; w++) begin
            set_cmd(2, C_WORD, msg[w]);
            step();
        end
        clear_cmds();
        set_cmd(1, C_WORD, 32'hDEADBEEF);
        step();
        clear_cmds();
        n_checks++;
        if (out_resp[1] !== 2'b10 || core_word_valid !== 1'b0 || dbg_word_cnt !== 4'd3 || out_resp[2] !== 2'b00) begin
            n_errors++;
            $display("FAIL nonowner_word resp2=%b valid=%b cnt=%0d resp3=%b expected 10/0/3/00",
                     out_resp[1], core_word_valid, dbg_word_cnt, out_resp[2]);
        end
        step();
        n_checks++;
        if (out_resp[1] !== 2'b00) begin
            n_errors++;
            $display("FAIL nonowner_clear resp2=%b expected 00", out_resp[1]);
        end
        set_cmd(0, 4'h7, 32'h0);
        step();
        clear_cmds();
        n_checks++;
        if (out_resp[0] !== 2'b10) begin
            n_errors++;
            $display("FAIL invalid_cmd resp1=%b expected 10", out_resp[0]);
        end
        step();
        n_checks++;
        if (out_resp[0] !== 2'b00) begin
            n_errors++;
            $display("FAIL invalid_one_cycle resp1=%b expected 00", out_resp[0]);
        end
        set_cmd(0, C_REQ, 32'h0);
        step();
        n_checks++;
        if (out_resp[0] !== 2'b00 || dbg_pending !== 4'b0001) begin
            n_errors++;
            $display("FAIL req_pending resp1=%b pend=%b expected 00/0001", out_resp[0], dbg_pending);
        end
        step();
        clear_cmds();
        n_checks++;
        if (out_resp[0] !== 2'b10 || dbg_pending !== 4'b0001) begin
            n_errors++;
            $display("FAIL dup_req resp1=%b pend=%b expected 10/0001", out_resp[0], dbg_pending);
        end
        set_cmd(2, C_REQ, 32'h0);
        step();
        clear_cmds();
        n_checks++;
        if (out_resp[2] !== 2'b10 || dbg_word_cnt !== 4'd3) begin
            n_errors++;
            $display("FAIL owner_req resp3=%b cnt=%0d expected 10/3", out_resp[2], dbg_word_cnt);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_cmd(0, C_REQ, 32'h0);
        step();
        for (int w = 0; w < 7; w++) begin
            set_cmd(0, C_WORD, msg[w] | 32'h100);
            step();
        end
        n_checks++;
        if (core_word_valid !== 1'b1 || dbg_word_cnt !== 4'd7) begin
            n_errors++;
            $display("FAIL mid_pre valid=%b cnt=%0d expected 1/7", core_word_valid, dbg_word_cnt);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (core_word_valid !== 1'b0 || core_word !== 32'h0 || core_start !== 1'b0 || out_resp[0] !== 2'b00 ||
            dbg_state !== 2'd0 || dbg_word_cnt !== 4'd0) begin
            n_errors++;
            $display("FAIL mid_async valid=%b word=%h start=%b resp1=%b state=%0d cnt=%0d expected zeros",
                     core_word_valid, core_word, core_start, out_resp[0], dbg_state, dbg_word_cnt);
        end
        clear_cmds();
        step();
        rst = 1'b1;
        set_cmd(1, C_REQ, 32'h0);
        step();
        n_checks++;
        if (out_resp[1] !== 2'b11 || out_resp[0] !== 2'b00) begin
            n_errors++;
            $display("FAIL mid_regrant resp2=%b resp1=%b expected 11/00", out_resp[1], out_resp[0]);
        end
        set_cmd(1, C_WORD, 32'h12345678);
        step();
        clear_cmds();
        n_checks++;
        if (core_start !== 1'b1 || core_word !== 32'h12345678 || dbg_word_cnt !== 4'd1) begin
            n_errors++;
            $display("FAIL mid_restart start=%b word=%h cnt=%0d expected 1/12345678/1", core_start, core_word, dbg_word_cnt);
        end
    endtask

    task automatic test_rr_wrap();
        apply_reset();
        set_cmd(3, C_REQ, 32'h0);
        step();
        clear_cmds();
        feed_words(3);
        pulse_done(ABC_DIGEST);
        repeat (8) step();
        n_checks++;
        if (dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL wrap_idle state=%0d expected 0", dbg_state);
        end
        set_cmd(0, C_REQ, 32'h0);
        set_cmd(3, C_REQ, 32'h0);
        step();
        clear_cmds();
        n_checks++;
        if (out_resp[0] !== 2'b11 || out_resp[3] !== 2'b00 || dbg_pending !== 4'b1000) begin
            n_errors++;
            $display("FAIL wrap_grant resp1=%b resp4=%b pend=%b expected 11/00/1000", out_resp[0], out_resp[3], dbg_pending);
        end
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        abc_h[0] = 32'hBA7816BF; abc_h[1] = 32'h8F01CFEA;
        abc_h[2] = 32'h414140DE; abc_h[3] = 32'h5DAE2223;
        abc_h[4] = 32'hB00361A3; abc_h[5] = 32'h96177A9C;
        abc_h[6] = 32'hB410FF61; abc_h[7] = 32'hF20015AD;
        for (int w = 0; w < 16; w++) msg[w] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;

        test_reset();
        test_single_hash();
        test_round_robin();
        test_errors();
        test_reset_mid();
        test_rr_wrap();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
